// File: rtl/panda_input_pkg.sv
// Shared types and helpers for the panda input conditioner.
// Debounce FSM state encoding, channel limit and counter width function.
package panda_input_pkg;

    localparam int unsigned MAX_INPUTS = 32;

    typedef enum logic [1:0] {
        STABLE_LO,
        CHK_HI,
        STABLE_HI,
        CHK_LO
    } deb_state_t;

    // Counter holds 0..cycles, so it needs enough bits for cycles itself.
    function automatic int unsigned debounce_w(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/panda_debounce_channel.sv
// One input channel: 2-flop synchroniser, debounce FSM/counter and registered pulses.
// accept_rise/accept_fall flag the edge on which a change is accepted.
module panda_debounce_channel
    import panda_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic accept_rise,
    output logic accept_fall
);

    localparam int unsigned CNT_W = debounce_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync_q1;
    logic             sync_q2;
    deb_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= raw_in;
            sync_q2 <= sync_q1;
        end
    end

    // Strobes derive from registered state only, never from raw_in.
    always_comb begin
        accept_rise = (state_q == CHK_HI) && sync_q2 && (cnt_q == CNT_MAX);
        accept_fall = (state_q == CHK_LO) && !sync_q2 && (cnt_q == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= STABLE_LO;
            cnt_q      <= '0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            case (state_q)
                STABLE_LO: begin
                    if (sync_q2) begin
                        state_q <= CHK_HI;
                        cnt_q   <= CNT_ONE;
                    end
                end
                CHK_HI: begin
                    if (!sync_q2) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q    <= STABLE_HI;
                        cnt_q      <= '0;
                        rise_pulse <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STABLE_HI: begin
                    if (!sync_q2) begin
                        state_q <= CHK_LO;
                        cnt_q   <= CNT_ONE;
                    end
                end
                CHK_LO: begin
                    if (sync_q2) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q    <= STABLE_LO;
                        cnt_q      <= '0;
                        fall_pulse <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= STABLE_LO;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/panda_input_conditioner.sv
// Multi-channel board input conditioner: synchronise, debounce, edge-detect per pin.
// Optional per-channel toggle behaviour enabled by defining PANDA_INPUT_TOGGLE_EN.
module panda_input_conditioner
    import panda_input_pkg::*;
#(
    parameter int unsigned NUM_INPUTS      = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_INPUTS-1:0] raw_in,
`ifdef PANDA_INPUT_TOGGLE_EN
    input  logic [NUM_INPUTS-1:0] toggle_mode,
`endif
    output logic [NUM_INPUTS-1:0] level_out,
    output logic [NUM_INPUTS-1:0] rise_pulse,
    output logic [NUM_INPUTS-1:0] fall_pulse
);

    logic [NUM_INPUTS-1:0] accept_rise;
    logic [NUM_INPUTS-1:0] accept_fall;
    logic [NUM_INPUTS-1:0] level_q;
`ifdef PANDA_INPUT_TOGGLE_EN
    logic [NUM_INPUTS-1:0] tog_latch_q;
`endif

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_chan
        panda_debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .raw_in     (raw_in[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i]),
            .accept_rise(accept_rise[i]),
            .accept_fall(accept_fall[i])
        );
    end

    // Level register updates on the same edge as the channel pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
`ifdef PANDA_INPUT_TOGGLE_EN
            tog_latch_q <= '0;
`endif
        end else begin
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
`ifdef PANDA_INPUT_TOGGLE_EN
                // Mode is captured at each accepted rise and governs the following fall.
                if (accept_rise[i]) begin
                    level_q[i]     <= toggle_mode[i] ? ~level_q[i] : 1'b1;
                    tog_latch_q[i] <= toggle_mode[i];
                end else if (accept_fall[i] && !tog_latch_q[i]) begin
                    level_q[i] <= 1'b0;
                end
`else
                if (accept_rise[i]) begin
                    level_q[i] <= 1'b1;
                end else if (accept_fall[i]) begin
                    level_q[i] <= 1'b0;
                end
`endif
            end
        end
    end

    assign level_out = level_q;

endmodule

// File: tb/tb_panda_input_conditioner.sv
// Randomised self-checking bench for panda_input_conditioner against a run-length reference model.
// Covers the toggle feature when PANDA_INPUT_TOGGLE_EN is defined.
module tb_panda_input_conditioner;

    localparam int NUM = 4;
    localparam int DEB = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NUM-1:0] raw_in;
    logic [NUM-1:0] level_out;
    logic [NUM-1:0] rise_pulse;
    logic [NUM-1:0] fall_pulse;
`ifdef PANDA_INPUT_TOGGLE_EN
    logic [NUM-1:0] toggle_mode;
`endif

    always #5 clk = ~clk;

    panda_input_conditioner #(
        .NUM_INPUTS     (NUM),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_in     (raw_in),
`ifdef PANDA_INPUT_TOGGLE_EN
        .toggle_mode(toggle_mode),
`endif
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    string phase = "init";

    // Reference: pins reach the debouncer two samples late; a change is accepted
    // once DEB+1 consecutive samples differ from the accepted level.
    bit [NUM-1:0] pin_delay[$];
    int           run_len[NUM];
    bit [NUM-1:0] deb_lvl, exp_level, exp_rise, exp_fall, tog_sel;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s.%s: got %0h expected %0h at %0t", phase, tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        pin_delay.delete();
        pin_delay.push_back('0);
        pin_delay.push_back('0);
        for (int i = 0; i < NUM; i++) run_len[i] = 0;
        deb_lvl   = '0;
        exp_level = '0;
        exp_rise  = '0;
        exp_fall  = '0;
        tog_sel   = '0;
    endtask

    task automatic model_edge();
        bit [NUM-1:0] s;
        bit tm;
        if (!rst_n) begin
            model_clear();
        end else begin
            s = pin_delay.pop_front();
            pin_delay.push_back(raw_in);
            exp_rise = '0;
            exp_fall = '0;
            for (int i = 0; i < NUM; i++) begin
`ifdef PANDA_INPUT_TOGGLE_EN
                tm = toggle_mode[i];
`else
                tm = 1'b0;
`endif
                run_len[i] = (s[i] != deb_lvl[i]) ? run_len[i] + 1 : 0;
                if (run_len[i] == DEB + 1) begin
                    run_len[i] = 0;
                    deb_lvl[i] = s[i];
                    if (s[i]) begin
                        exp_rise[i]  = 1'b1;
                        exp_level[i] = tm ? ~exp_level[i] : 1'b1;
                        tog_sel[i]   = tm;
                    end else begin
                        exp_fall[i] = 1'b1;
                        if (!tog_sel[i]) exp_level[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("level", 32'(level_out), 32'(exp_level));
        check("rise", 32'(rise_pulse), 32'(exp_rise));
        check("fall", 32'(fall_pulse), 32'(exp_fall));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without waiting for a clock.
    task automatic pulse_reset(input int hold);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check("rst_level", 32'(level_out), 32'd0);
        check("rst_rise", 32'(rise_pulse), 32'd0);
        check("rst_fall", 32'(fall_pulse), 32'd0);
        ticks(hold);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rise_at;
        int n_rise, n_fall;
        int lvl_seq[$];

        rst_n  = 1'b0;
        raw_in = '0;
`ifdef PANDA_INPUT_TOGGLE_EN
        toggle_mode = '0;
`endif
        model_clear();
        #1;
        phase = "reset";
        check("por_level", 32'(level_out), 32'd0);
        ticks(3);
        rst_n = 1'b1;
        ticks(3);

        phase = "press0";
        raw_in[0] = 1'b1;
        rise_at = -1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (rise_pulse[0] && rise_at < 0) rise_at = k;
        end
        check("rise_latency", 32'(rise_at), 32'(2 + DEB));
        check("others_low", 32'(level_out[3:1]), 32'd0);

        phase = "short1";
        raw_in[1] = 1'b1;
        ticks(3);
        raw_in[1] = 1'b0;
        ticks(10);
        check("short_level", 32'(level_out[1]), 32'd0);

        phase = "bounce3";
        foreach (lvl_seq[k]) lvl_seq.delete();
        lvl_seq = '{1, 0, 1, 1, 0, 1};
        n_rise = 0;
        n_fall = 0;
        foreach (lvl_seq[k]) begin
            raw_in[3] = lvl_seq[k][0];
            tick();
            n_rise += int'(rise_pulse[3]);
            n_fall += int'(fall_pulse[3]);
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            n_rise += int'(rise_pulse[3]);
            n_fall += int'(fall_pulse[3]);
        end
        check("bounce_rises", 32'(n_rise), 32'd1);
        check("bounce_falls", 32'(n_fall), 32'd0);

        phase = "held_reset";
        raw_in = '1;
        pulse_reset(2);
        rise_at = -1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (rise_pulse == '1 && rise_at < 0) rise_at = k;
        end
        check("all_rise_latency", 32'(rise_at), 32'(2 + DEB));

        phase = "mid_reset";
        raw_in = '0;
        ticks(10);
        raw_in[2] = 1'b1;
        ticks(4);
        pulse_reset(1);
        ticks(10);
        check("restart_level", 32'(level_out[2]), 32'd1);

`ifdef PANDA_INPUT_TOGGLE_EN
        phase = "toggle2";
        raw_in = '0;
        toggle_mode = '0;
        ticks(10);
        pulse_reset(1);
        toggle_mode[2] = 1'b1;
        n_rise = 0;
        n_fall = 0;
        lvl_seq.delete();
        for (int p = 0; p < 3; p++) begin
            raw_in[2] = 1'b1;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (rise_pulse[2]) begin
                    n_rise++;
                    lvl_seq.push_back(int'(level_out[2]));
                end
            end
            raw_in[2] = 1'b0;
            for (int k = 0; k < 10; k++) begin
                tick();
                n_fall += int'(fall_pulse[2]);
            end
        end
        check("tog_rises", 32'(n_rise), 32'd3);
        check("tog_falls", 32'(n_fall), 32'd3);
        check("tog_seq_len", 32'(lvl_seq.size()), 32'd3);
        if (lvl_seq.size() == 3) begin
            check("tog_seq0", 32'(lvl_seq[0]), 32'd1);
            check("tog_seq1", 32'(lvl_seq[1]), 32'd0);
            check("tog_seq2", 32'(lvl_seq[2]), 32'd1);
        end
`endif

        phase = "random";
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NUM; i++) begin
                if ($urandom_range(0, (c < 750) ? 5 : 12) == 0) raw_in[i] = ~raw_in[i];
            end
`ifdef PANDA_INPUT_TOGGLE_EN
            if ($urandom_range(0, 19) == 0) toggle_mode = NUM'($urandom);
`endif
            if ($urandom_range(0, 299) == 0) pulse_reset(int'($urandom_range(1, 3)));
            else tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
